// File: rtl/queue_ctrl.sv
// Pointer, occupancy and status controller for a single-clock queue built around an
// external dual-port memory. Status flags are decoded from the registered count.
module queue_ctrl #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AW       = 3,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_req,
  input  logic          pop_req,
  input  logic          clr_err,
  output logic          we_dual,
  output logic [AW-1:0] addr_wr,
  output logic [AW-1:0] addr_rd,
  output logic [AW:0]   fifo_cnt,
  output logic          empty,
  output logic          full,
  output logic          almost_empty,
  output logic          almost_full,
  output logic          overflow,
  output logic          underflow
);

  localparam logic [AW:0] CntFull = (AW + 1)'(DEPTH);
  localparam logic [AW:0] CntAf   = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] CntAe   = (AW + 1)'(AE_LEVEL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push_ok, pop_ok;

  assign empty        = (cnt_q == '0);
  assign full         = (cnt_q == CntFull);
  assign almost_full  = (cnt_q >= CntAf);
  assign almost_empty = (cnt_q <= CntAe);

  // A pop frees the slot in the same edge, so a push while full is still accepted.
  assign pop_ok  = pop_req & ~empty;
  assign push_ok = push_req & (~full | pop_ok);

  // Gate with reset so the memory never sees a write while state is being held cleared.
  assign we_dual  = push_ok & rst;
  assign addr_wr  = wr_ptr_q;
  assign addr_rd  = rd_ptr_q;
  assign fifo_cnt = cnt_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);

    if (push_ok && !pop_ok)      cnt_d = cnt_q + (AW + 1)'(1);
    else if (pop_ok && !push_ok) cnt_d = cnt_q - (AW + 1)'(1);

    // A fresh error wins over a clear in the same cycle.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (push_req && !push_ok) overflow_d  = 1'b1;
    if (pop_req && !pop_ok)   underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_queue_ctrl.sv
// Directed bench for queue_ctrl: a queue-based model plus an emulated dual-port memory,
// compared against the DUT on every falling edge, with literal spot checks.
module tb_queue_ctrl;

  localparam int DEPTH    = 8;
  localparam int AW       = 3;
  localparam int AF_LEVEL = 6;
  localparam int AE_LEVEL = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push_req = 1'b0;
  logic          pop_req = 1'b0;
  logic          clr_err = 1'b0;
  logic [7:0]    din = 8'h00;
  logic          we_dual;
  logic [AW-1:0] addr_wr, addr_rd;
  logic [AW:0]   fifo_cnt;
  logic          empty, full, almost_empty, almost_full, overflow, underflow;

  int checks = 0;
  int errors = 0;

  // Model state
  int   mq[$];
  int   m_wr = 0;
  int   m_rd = 0;
  bit   m_ovf = 1'b0;
  bit   m_unf = 1'b0;
  logic [7:0] mem [DEPTH];

  queue_ctrl #(
    .DEPTH(DEPTH), .AW(AW), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push_req     (push_req),
    .pop_req      (pop_req),
    .clr_err      (clr_err),
    .we_dual      (we_dual),
    .addr_wr      (addr_wr),
    .addr_rd      (addr_rd),
    .fifo_cnt     (fifo_cnt),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update and memory emulation; the memory writes wherever the DUT says.
  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        m_wr  = 0;
        m_rd  = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        bit pop_ok, push_ok;
        pop_ok  = pop_req && (mq.size() > 0);
        push_ok = push_req && ((mq.size() < DEPTH) || pop_ok);
        if (we_dual) mem[addr_wr] = din;
        if (clr_err) begin
          m_ovf = 1'b0;
          m_unf = 1'b0;
        end
        if (push_req && !push_ok) m_ovf = 1'b1;
        if (pop_req && !pop_ok)   m_unf = 1'b1;
        if (pop_ok) begin
          void'(mq.pop_front());
          m_rd = (m_rd + 1) % DEPTH;
        end
        if (push_ok) begin
          mq.push_back(int'(din));
          m_wr = (m_wr + 1) % DEPTH;
        end
      end
    end
  end

  // Single compare process
  always @(negedge clk) begin
    int  n;
    bit  exp_we;
    n = mq.size();
    exp_we = rst && push_req && ((n < DEPTH) || (pop_req && n > 0));
    chk("fifo_cnt", 32'(fifo_cnt), 32'(n));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(n >= AF_LEVEL));
    chk("almost_empty", 32'(almost_empty), 32'(n <= AE_LEVEL));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("addr_wr", 32'(addr_wr), 32'(m_wr));
    chk("addr_rd", 32'(addr_rd), 32'(m_rd));
    chk("we_dual", 32'(we_dual), 32'(exp_we));
    if (n > 0) chk("head_data", 32'(mem[addr_rd]), 32'(mq[0]));
  end

  // Apply inputs for one cycle; returns just after the edge that consumed them.
  task automatic step(input logic p, input logic q, input logic c, input logic [7:0] d);
    push_req = p;
    pop_req  = q;
    clr_err  = c;
    din      = d;
    @(posedge clk);
    #1;
    push_req = 1'b0;
    pop_req  = 1'b0;
    clr_err  = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_cnt", 32'(fifo_cnt), 32'd0);
    chk("reset_ae", 32'(almost_empty), 32'd1);
    push_req = 1'b1;
    #1;
    chk("reset_we_forced_low", 32'(we_dual), 32'd0);
    push_req = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Pop from reset-empty
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("pop_empty_unf", 32'(underflow), 32'd1);
    chk("pop_empty_rd", 32'(addr_rd), 32'd0);
    chk("pop_empty_cnt", 32'(fifo_cnt), 32'd0);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("clr_unf", 32'(underflow), 32'd0);

    // Fill
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h10 + i));
    chk("fill_cnt", 32'(fifo_cnt), 32'd8);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_af", 32'(almost_full), 32'd1);
    chk("fill_wr", 32'(addr_wr), 32'd0);

    // Push while full, then clear
    step(1'b1, 1'b0, 1'b0, 8'hEE);
    chk("ovf_cnt", 32'(fifo_cnt), 32'd8);
    chk("ovf_set", 32'(overflow), 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Push+pop while full
    step(1'b1, 1'b1, 1'b0, 8'h20);
    chk("pp_full_cnt", 32'(fifo_cnt), 32'd8);
    chk("pp_full_wr", 32'(addr_wr), 32'd1);
    chk("pp_full_rd", 32'(addr_rd), 32'd1);

    // Drain
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("drain_empty", 32'(empty), 32'd1);

    // Push+pop while empty
    step(1'b1, 1'b1, 1'b0, 8'h30);
    chk("pp_empty_cnt", 32'(fifo_cnt), 32'd1);
    chk("pp_empty_unf", 32'(underflow), 32'd1);
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("pp_empty_drain", 32'(fifo_cnt), 32'd0);

    // Interleaved traffic wraps both pointers
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
      step(1'b0, 1'b1, 1'b0, 8'h00);
    end
    chk("wrap_wr", 32'(addr_wr), 32'd4);
    chk("wrap_rd", 32'(addr_rd), 32'd4);

    // New error beats a clear in the same cycle
    step(1'b0, 1'b1, 1'b1, 8'h00);
    chk("err_priority", 32'(underflow), 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Asynchronous reset with five entries queued
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h60 + i));
    chk("pre_rst_cnt", 32'(fifo_cnt), 32'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("async_empty", 32'(empty), 32'd1);
    chk("async_cnt", 32'(fifo_cnt), 32'd0);
    chk("async_wr", 32'(addr_wr), 32'd0);
    chk("async_rd", 32'(addr_rd), 32'd0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 1'b0, 1'b0, 8'h77);
    chk("post_rst_wr", 32'(addr_wr), 32'd1);
    chk("post_rst_mem0", 32'(mem[0]), 32'h77);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, limit 100000 ns");
    $fatal(1);
  end

endmodule

// File: doc/queue_ctrl.md
QUEUE_CTRL -- requirements
Module: queue_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: number of entries in the downstream dual-port memory; power of two.
REQ-002 Parameter AW, default 3: address width, log2(DEPTH).
REQ-003 Parameter AF_LEVEL, default 6: almost_full threshold in entries.
REQ-004 Parameter AE_LEVEL, default 1: almost_empty threshold in entries.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous assert, active-low.
REQ-007 push_req  input  1  producer requests a write of the current din into the queue.
REQ-008 pop_req  input  1  consumer requests removal of the head entry.
REQ-009 clr_err  input  1  synchronous clear of sticky error flags.
REQ-010 we_dual  output  1  write enable to the memory stage.
REQ-011 addr_wr  output  AW  write address, equal to the write pointer.
REQ-012 addr_rd  output  AW  read address, equal to the read pointer; the memory's dout_dual at this address is the head entry.
REQ-013 fifo_cnt  output  AW+1  occupancy, 0..DEPTH.
REQ-014 empty, full, almost_empty, almost_full  outputs  1 each  status flags.
REQ-015 overflow, underflow  outputs  1 each  sticky error flags.

Function
REQ-016 Defines pop_ok = pop_req & ~empty.
REQ-017 Defines push_ok = push_req & (~full | pop_ok).
REQ-018 we_dual shall equal push_ok combinationally, so the memory writes on the same rising edge the push is accepted.
REQ-019 On each edge with push_ok, wr_ptr shall increment by 1 modulo DEPTH; it wraps from DEPTH-1 to 0.
REQ-020 On each edge with pop_ok, rd_ptr shall increment by 1 modulo DEPTH; it wraps from DEPTH-1 to 0.
REQ-021 fifo_cnt shall increment on push_ok only, decrement on pop_ok only, and hold when both or neither occur.
REQ-022 fifo_cnt shall be registered and shall never exceed DEPTH or go below 0.
REQ-023 empty shall be 1 iff fifo_cnt==0; full shall be 1 iff fifo_cnt==DEPTH. Both are decoded from the registered count.
REQ-024 almost_full shall be 1 iff fifo_cnt>=AF_LEVEL; almost_empty shall be 1 iff fifo_cnt<=AE_LEVEL.
REQ-025 Push+pop while full: both accepted, count stays DEPTH, old head is read before overwrite at the same address.
REQ-026 Push+pop while empty: push accepted, pop rejected, underflow set, fifo_cnt becomes 1.
REQ-027 overflow shall be set on the edge after any cycle with push_req & ~push_ok; wr_ptr and fifo_cnt are unchanged by the rejected push.
REQ-028 underflow shall be set on the edge after any cycle with pop_req & ~pop_ok; rd_ptr and fifo_cnt are unchanged by the rejected pop.
REQ-029 clr_err shall clear both error flags on the next edge; a new error in the same cycle takes priority, and that flag is set.
REQ-030 Error flags shall have no effect on push or pop acceptance.

Reset
REQ-031 While rst==0: wr_ptr=0, rd_ptr=0, fifo_cnt=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
REQ-032 While rst==0, we_dual shall be forced to 0 regardless of push_req.
REQ-033 Reset asserted mid-operation shall discard all occupancy immediately, without waiting for a clock edge; memory contents are not cleared.
REQ-034 After rst rises, the first accepted push shall use addr_wr=0.

Verification
REQ-035 Scenario: 8 consecutive pushes from reset -> addr_wr 0..7 with we_dual=1 on each; then fifo_cnt=8, full=1, almost_full=1, addr_wr=0.
REQ-036 Scenario: 9th push while full -> we_dual=0, fifo_cnt stays 8, overflow=1 next cycle; then clr_err -> overflow=0.
REQ-037 Scenario: pop from reset-empty -> underflow=1, rd_ptr=0, fifo_cnt=0.
REQ-038 Scenario: push+pop together while full -> fifo_cnt=8, both pointers advance by 1; push+pop together while empty -> fifo_cnt=1, underflow=1.
REQ-039 Scenario: 10 pushes interleaved with 10 pops -> pointers wrap past 7 to 0, read-data order matches write order.
REQ-040 Scenario: rst pulsed low between edges with fifo_cnt=5 -> empty=1, fifo_cnt=0, pointers 0, all before the next edge.
